// File: rtl/my_mem_pkg.sv
// Shared types and parity helpers for the parity-protected memory requester.
package my_mem_pkg;
  localparam int ADDR_W = 16;
  localparam int DATA_W = 8;

  typedef enum logic [2:0] {IDLE, WRITE, READ, CAPTURE, RESP} state_t;

  // Memory word layout is {parity, data}; parity makes the total even.
  function automatic logic [DATA_W:0] calc_even_parity(input logic [DATA_W-1:0] d);
    return {^d, d};
  endfunction

  function automatic logic parity_ok(input logic [DATA_W:0] w);
    return ~^w;
  endfunction
endpackage

// File: rtl/my_mem_requester_if.sv
// Request/response handshake between the CPU-side agent and the requester.
interface my_mem_requester_if #(parameter int ADDR_W = 16, parameter int DATA_W = 8);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_parity_err;

  modport master (output req_valid, req_write, req_addr, req_wdata, rsp_ready,
                  input  req_ready, rsp_valid, rsp_rdata, rsp_parity_err);
  modport slave  (input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
                  output req_ready, rsp_valid, rsp_rdata, rsp_parity_err);
endinterface

// File: rtl/my_mem_parity_chk.sv
// Splits a {parity, data} memory word and flags odd overall parity.
module my_mem_parity_chk #(parameter int DATA_W = 8) (
  input  logic [DATA_W:0]   word,
  output logic [DATA_W-1:0] data,
  output logic              err
);
  assign data = word[DATA_W-1:0];
  assign err  = ^word;
endmodule

// File: rtl/my_mem_requester.sv
// Single-outstanding memory initiator: issues write/read strobes, decodes parity on reads.
module my_mem_requester #(
  parameter int ADDR_W = my_mem_pkg::ADDR_W,
  parameter int DATA_W = my_mem_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  my_mem_requester_if.slave bus,
  output logic [15:0]       err_count,
  output logic              mem_write,
  output logic              mem_read,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data_in,
  input  logic [DATA_W:0]   mem_data_out
);
  import my_mem_pkg::*;

  state_t            state;
  logic [DATA_W-1:0] chk_data;
  logic              chk_err;

  my_mem_parity_chk #(.DATA_W(DATA_W)) u_chk (
    .word (mem_data_out),
    .data (chk_data),
    .err  (chk_err)
  );

  // mem_address/mem_data_in double as the request latches; they hold between strobes.
  always_ff @(posedge clk) begin
    if (reset) begin
      state              <= IDLE;
      bus.req_ready      <= 1'b0;
      bus.rsp_valid      <= 1'b0;
      bus.rsp_rdata      <= '0;
      bus.rsp_parity_err <= 1'b0;
      mem_write          <= 1'b0;
      mem_read           <= 1'b0;
      mem_address        <= '0;
      mem_data_in        <= '0;
      err_count          <= '0;
    end else begin
      mem_write <= 1'b0;
      mem_read  <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.req_valid && bus.req_ready) begin
            bus.req_ready <= 1'b0;
            mem_address   <= bus.req_addr;
            if (bus.req_write) begin
              mem_data_in <= bus.req_wdata;
              mem_write   <= 1'b1;
              state       <= WRITE;
            end else begin
              mem_read <= 1'b1;
              state    <= READ;
            end
          end else begin
            bus.req_ready <= 1'b1;
          end
        end
        WRITE: begin
          bus.req_ready <= 1'b1;
          state         <= IDLE;
        end
        READ: state <= CAPTURE;
        CAPTURE: begin
          bus.rsp_rdata      <= chk_data;
          bus.rsp_parity_err <= chk_err;
          bus.rsp_valid      <= 1'b1;
          if (chk_err && err_count != 16'hFFFF) err_count <= err_count + 16'd1;
          state <= RESP;
        end
        RESP: begin
          if (bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
            bus.req_ready <= 1'b1;
            state         <= IDLE;
          end
        end
        default: begin
          bus.req_ready <= 1'b0;
          bus.rsp_valid <= 1'b0;
          state         <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_my_mem_requester.sv
// Bench for my_mem_requester: table vectors, hand sequences, and random traffic vs. a memory model.
module tb_my_mem_requester;
  import my_mem_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] err_count;
  logic        mem_write, mem_read;
  logic [15:0] mem_address;
  logic [7:0]  mem_data_in;
  logic [8:0]  mem_data_out;

  my_mem_requester_if #(.ADDR_W(16), .DATA_W(8)) bus ();

  my_mem_requester dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus),
    .err_count    (err_count),
    .mem_write    (mem_write),
    .mem_read     (mem_read),
    .mem_address  (mem_address),
    .mem_data_in  (mem_data_in),
    .mem_data_out (mem_data_out)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Memory with a registered read port; corrupt_en replaces the next read word.
  logic [8:0] mem_arr [int];
  logic [8:0] mem_q = 9'h000;
  logic       corrupt_en = 1'b0;
  logic [8:0] corrupt_word = 9'h000;
  assign mem_data_out = mem_q;

  initial begin
    forever begin
      @(posedge clk);
      if (mem_write) mem_arr[int'(mem_address)] = calc_even_parity(mem_data_in);
      if (mem_read)
        mem_q <= corrupt_en ? corrupt_word :
                 (mem_arr.exists(int'(mem_address)) ? mem_arr[int'(mem_address)] : 9'h000);
    end
  end

  // Reference: what each address last had written, and the expected error tally.
  logic [7:0] ref_mem [int];
  int         ref_cnt = 0;

  task automatic do_txn(input logic wr, input logic [15:0] a, input logic [7:0] d,
                        input logic corrupt, input logic [8:0] cw, input int hold,
                        input logic [7:0] erd, input logic epe, input logic [15:0] ecnt);
    int t = 0;
    while (!bus.req_ready && t < 20) begin @(negedge clk); t++; end
    chk("req_ready_before_req", bus.req_ready, 1);
    bus.req_valid = 1'b1; bus.req_write = wr; bus.req_addr = a; bus.req_wdata = d;
    bus.rsp_ready = (hold == 0);
    corrupt_en = corrupt; corrupt_word = cw;
    @(negedge clk);
    bus.req_valid = 1'b0;
    chk("mem_write_strobe", mem_write, wr);
    chk("mem_read_strobe", mem_read, !wr);
    chk("mem_address", mem_address, a);
    chk("req_ready_busy", bus.req_ready, 0);
    if (wr) begin
      chk("mem_data_in", mem_data_in, d);
      @(negedge clk);
      chk("write_done_strobe", mem_write, 0);
      chk("write_done_ready", bus.req_ready, 1);
    end else begin
      @(negedge clk);
      corrupt_en = 1'b0;
      chk("capture_strobe", mem_read, 0);
      chk("capture_no_rsp", bus.rsp_valid, 0);
      @(negedge clk);
      chk("rsp_valid_n3", bus.rsp_valid, 1);
      chk("rsp_rdata", bus.rsp_rdata, erd);
      chk("rsp_parity_err", bus.rsp_parity_err, epe);
      chk("err_count", err_count, ecnt);
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        chk("bp_valid", bus.rsp_valid, 1);
        chk("bp_rdata", bus.rsp_rdata, erd);
        chk("bp_perr", bus.rsp_parity_err, epe);
        chk("bp_ready", bus.req_ready, 0);
        chk("bp_no_read", mem_read, 0);
      end
      bus.rsp_ready = 1'b1;
      @(negedge clk);
      chk("rsp_done_valid", bus.rsp_valid, 0);
      chk("rsp_done_ready", bus.req_ready, 1);
    end
  endtask

  typedef struct {
    logic        wr;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic        corrupt;
    logic [8:0]  cw;
    int          hold;
    logic [7:0]  erd;
    logic        epe;
    logic [15:0] ecnt;
  } vec_t;

  vec_t tbl [10];

  initial begin
    tbl[0] = '{1'b1, 16'h0010, 8'h07, 1'b0, 9'h000, 0, 8'h00, 1'b0, 16'd0};
    tbl[1] = '{1'b0, 16'h0010, 8'h00, 1'b0, 9'h000, 0, 8'h07, 1'b0, 16'd0};
    tbl[2] = '{1'b0, 16'h0010, 8'h00, 1'b1, 9'h007, 0, 8'h07, 1'b1, 16'd1};
    tbl[3] = '{1'b0, 16'h0010, 8'h00, 1'b0, 9'h000, 5, 8'h07, 1'b0, 16'd1};
    tbl[4] = '{1'b0, 16'h00FF, 8'h00, 1'b0, 9'h000, 0, 8'h00, 1'b0, 16'd1};
    tbl[5] = '{1'b1, 16'h1234, 8'hA5, 1'b0, 9'h000, 0, 8'h00, 1'b0, 16'd1};
    tbl[6] = '{1'b0, 16'h1234, 8'h00, 1'b0, 9'h000, 1, 8'hA5, 1'b0, 16'd1};
    tbl[7] = '{1'b1, 16'hFFFF, 8'hFF, 1'b0, 9'h000, 0, 8'h00, 1'b0, 16'd1};
    tbl[8] = '{1'b0, 16'hFFFF, 8'h00, 1'b0, 9'h000, 0, 8'hFF, 1'b0, 16'd1};
    tbl[9] = '{1'b0, 16'h0000, 8'h00, 1'b1, 9'h0FE, 0, 8'hFE, 1'b1, 16'd2};

    reset = 1'b1;
    bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_addr = 16'hABCD;
    bus.req_wdata = 8'h5A; bus.rsp_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("rst_req_ready", bus.req_ready, 0);
      chk("rst_rsp_valid", bus.rsp_valid, 0);
      chk("rst_perr", bus.rsp_parity_err, 0);
      chk("rst_rdata", bus.rsp_rdata, 0);
      chk("rst_mem_write", mem_write, 0);
      chk("rst_mem_read", mem_read, 0);
      chk("rst_mem_address", mem_address, 0);
      chk("rst_mem_data_in", mem_data_in, 0);
      chk("rst_err_count", err_count, 0);
    end
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_req_ready", bus.req_ready, 1);
    chk("post_rst_no_write", mem_write, 0);
    bus.req_valid = 1'b0;

    for (int i = 0; i < 10; i++) begin
      do_txn(tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].corrupt, tbl[i].cw,
             tbl[i].hold, tbl[i].erd, tbl[i].epe, tbl[i].ecnt);
      if (tbl[i].wr) ref_mem[int'(tbl[i].addr)] = tbl[i].wdata;
      ref_cnt = int'(tbl[i].ecnt);
      if (i == 0) chk("mem_word_0010", mem_arr.exists(16) ? mem_arr[16] : 9'h1FF, 9'h107);
    end

    // Reset lands in the cycle mem_read is high: no response must follow.
    chk("midrst_idle", bus.req_ready, 1);
    bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_addr = 16'h0010;
    @(negedge clk);
    bus.req_valid = 1'b0;
    chk("midrst_read_cycle", mem_read, 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midrst_strobe", mem_read, 0);
    chk("midrst_write", mem_write, 0);
    chk("midrst_err_count", err_count, 0);
    ref_cnt = 0;
    repeat (4) begin
      @(negedge clk);
      chk("midrst_no_rsp", bus.rsp_valid, 0);
    end

    for (int i = 0; i < 40; i++) begin
      logic        wr, cor;
      logic [15:0] a;
      logic [7:0]  d, cd, erd;
      logic [8:0]  cw;
      int          hold;
      wr   = $urandom_range(0, 1) == 1;
      a    = 16'h0100 + 16'($urandom_range(0, 7));
      d    = 8'($urandom);
      cor  = !wr && ($urandom_range(0, 4) == 0);
      cd   = 8'($urandom);
      cw   = {~^cd, cd};
      hold = $urandom_range(0, 2);
      if (cor) begin
        erd = cd;
        if (ref_cnt < 65535) ref_cnt++;
      end else begin
        erd = ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : 8'h00;
      end
      do_txn(wr, a, d, cor, cw, hold, erd, cor, 16'(ref_cnt));
      if (wr) ref_mem[int'(a)] = d;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/my_mem_requester.md
# my_mem_requester

Bus-side initiator for the parity-protected memory: accepts single read/write requests over a valid/ready handshake and drives the memory's `write`/`read`/`address`/`data_in` pins. On reads it captures the 9-bit parity-encoded `data_out` word, checks even parity, strips the parity bit and returns the 8-bit data with an error flag. It sits between the testbench/CPU-side agent and the memory, and is the decode end of the parity encode the memory performs on write.

## Interface
- `ADDR_W`, 16, memory address width
- `DATA_W`, 8, payload width; memory word is `DATA_W+1` (`{parity, data}`)

- `clk`  in  1  sole clock, rising edge
- `reset`  in  1  synchronous, active-high
- `req_valid`  in  1  request present
- `req_ready`  out  1  requester idle, request accepted when both high
- `req_write`  in  1  1 = write, 0 = read
- `req_addr`  in  ADDR_W  target address
- `req_wdata`  in  DATA_W  write payload
- `rsp_valid`  out  1  read response present
- `rsp_ready`  in  1  consumer accepts response
- `rsp_rdata`  out  DATA_W  read payload, parity stripped
- `rsp_parity_err`  out  1  parity of captured word was odd
- `err_count`  out  16  saturating count of parity errors
- `mem_write`  out  1  memory write strobe
- `mem_read`  out  1  memory read strobe
- `mem_address`  out  ADDR_W  memory address
- `mem_data_in`  out  DATA_W  memory write data
- `mem_data_out`  in  DATA_W+1  memory read word `{parity, data}`

## Operation
- FSM states: IDLE, WRITE, READ, CAPTURE, RESP.
- IDLE: `req_ready`=1. On `req_valid && req_ready` latch write/addr/wdata; go WRITE if `req_write`, else READ.
- WRITE: `mem_write`=1, `mem_address`/`mem_data_in` from latches; -> IDLE. No response issued.
- READ: `mem_read`=1, `mem_address` from latch; -> CAPTURE.
- CAPTURE: strobes low; sample `mem_data_out`; `rsp_rdata` <= bits `[DATA_W-1:0]`; `rsp_parity_err` <= `^mem_data_out` (1 = odd = error); if error and `err_count` != 16'hFFFF, increment; -> RESP.
- RESP: `rsp_valid`=1; `rsp_rdata`/`rsp_parity_err` stable; on `rsp_ready` -> IDLE.
- `mem_write` and `mem_read` never both high; each high for exactly one cycle per request.
- All outputs registered; `mem_address`/`mem_data_in` hold last value when strobes low.
- Unwritten address reads as 9'h000: parity OK, data 0.

## Timing
- Reset (while `reset`=1 and on the following edge): state IDLE; `req_ready`, `rsp_valid`, `rsp_parity_err`, `mem_write`, `mem_read` = 0; `rsp_rdata`, `mem_address`, `mem_data_in` = 0; `err_count` = 0. `req_ready`=1 in first cycle after reset deasserts.
- Handshake in cycle N. Write: `mem_write` high in N+1; `req_ready` high again in N+2.
- Read: `mem_read` high in N+1; `mem_data_out` valid in N+2 (memory updates on N+1 edge) and is sampled at end of N+2; `rsp_valid` high from N+3.
- With `rsp_ready` tied high, throughput: one read per 4 cycles, one write per 2.
- `req_ready` is 0 in every state except IDLE; no request queuing.
- Reset mid-transaction: in-flight request dropped, no response, strobes low next cycle, `err_count` cleared.
- `err_count` saturates at 16'hFFFF; `rsp_parity_err` still reports.

## Structure
- Package `my_mem_pkg`: `ADDR_W`/`DATA_W` defaults, `state_t` enum (IDLE, WRITE, READ, CAPTURE, RESP), function `calc_even_parity` (returns `{^d, d}`), function `parity_ok`.
- One sub-module: `my_mem_parity_chk` (combinational: 9-bit word in, data out, error out), instantiated on `mem_data_out`.
- Top holds FSM, request latches, response registers, error counter.

## Test plan
- Reset: hold `reset` 3 cycles with `req_valid`=1 -> all outputs 0, no strobes; `req_ready`=1 first cycle after release.
- Write 0x07 to 0x0010, then read 0x0010 -> `mem_write` one cycle with addr 0x0010/data 0x07; memory word 9'h107; `rsp_rdata`=0x07, `rsp_parity_err`=0, `rsp_valid` exactly 3 cycles after read handshake.
- Corrupt read: bench forces `mem_data_out`=9'h007 in CAPTURE -> `rsp_rdata`=0x07, `rsp_parity_err`=1, `err_count`=1.
- Backpressure: `rsp_ready`=0 for 5 cycles after `rsp_valid` -> data/flag stable, `req_ready`=0, no extra `mem_read`; release -> IDLE next cycle.
- Reset asserted in the `mem_read` cycle -> no `rsp_valid`, strobes 0 next cycle, `err_count`=0.
- Read of never-written 0x00FF -> `rsp_rdata`=0x00, `rsp_parity_err`=0, `err_count` unchanged.
